// File: rtl/sig_dump_ctrl.sv
// Signature dump controller: snoops the begin/end/halt writes on the core data bus,
// then halts the core and streams the signature words out of data RAM.
module sig_dump_ctrl #(
    parameter logic [31:0] BEGIN_ADDR = 32'h508,
    parameter logic [31:0] END_ADDR   = 32'h50c,
    parameter logic [31:0] HALT_ADDR  = 32'h600,
    parameter logic [31:0] DRAM_BASE  = 32'h4000_0000,
    parameter int          DRAM_AW    = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               snoop_we,
    input  logic [31:0]        snoop_addr,
    input  logic [31:0]        snoop_wdat,
    output logic               dram_rd_req,
    output logic [DRAM_AW-1:0] dram_rd_idx,
    input  logic               dram_rd_gnt,
    input  logic [31:0]        dram_rd_dat,
    output logic               out_valid,
    output logic [31:0]        out_data,
    input  logic               out_ready,
    output logic               core_halt,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_SEND,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [32:0] WORD_LIMIT = 33'd1 << DRAM_AW;

    state_t             r_state;
    logic [31:0]        r_sig_begin;
    logic [31:0]        r_sig_end;
    logic [31:0]        r_cur_addr;
    logic [31:0]        r_out_data;
    logic [DRAM_AW-1:0] r_idx;
    logic               r_req;
    logic               r_valid;
    logic               r_halt;
    logic               r_done;
    logic               r_err;

    logic        w_misalign;
    logic        w_empty;
    logic        w_range_bad;
    logic [31:0] w_end_words;
    logic [31:0] w_next_addr;

    // Alignment is judged first, then emptiness, so an unprogrammed 0/0 range ends cleanly.
    assign w_misalign  = (|r_sig_begin[1:0]) || (|r_sig_end[1:0]);
    assign w_empty     = r_sig_begin >= r_sig_end;
    assign w_end_words = (r_sig_end - DRAM_BASE) >> 2;
    assign w_range_bad = (r_sig_begin < DRAM_BASE) ||
                         ({1'b0, w_end_words} > WORD_LIMIT);
    assign w_next_addr = r_cur_addr + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sig_begin <= '0;
            r_sig_end   <= '0;
            r_cur_addr  <= '0;
            r_out_data  <= '0;
            r_idx       <= '0;
            r_req       <= 1'b0;
            r_valid     <= 1'b0;
            r_halt      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (snoop_we) begin
                        if (snoop_addr == BEGIN_ADDR) begin
                            r_sig_begin <= snoop_wdat;
                        end else if (snoop_addr == END_ADDR) begin
                            r_sig_end <= snoop_wdat;
                        end else if (snoop_addr == HALT_ADDR) begin
                            r_halt <= 1'b1;
                            if (w_misalign) begin
                                r_err   <= 1'b1;
                                r_state <= S_ERR;
                            end else if (w_empty) begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else if (w_range_bad) begin
                                r_err   <= 1'b1;
                                r_state <= S_ERR;
                            end else begin
                                r_cur_addr <= r_sig_begin;
                                r_idx      <= DRAM_AW'((r_sig_begin - DRAM_BASE) >> 2);
                                r_req      <= 1'b1;
                                r_state    <= S_RD_REQ;
                            end
                        end
                    end
                end
                S_RD_REQ: begin
                    if (dram_rd_gnt) begin
                        r_req   <= 1'b0;
                        r_state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    r_out_data <= dram_rd_dat;
                    r_valid    <= 1'b1;
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    if (out_ready) begin
                        r_valid    <= 1'b0;
                        r_cur_addr <= w_next_addr;
                        if (w_next_addr == r_sig_end) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= DRAM_AW'((w_next_addr - DRAM_BASE) >> 2);
                            r_req   <= 1'b1;
                            r_state <= S_RD_REQ;
                        end
                    end
                end
                S_DONE: r_state <= S_DONE;
                S_ERR:  r_state <= S_ERR;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dram_rd_req = r_req;
    assign dram_rd_idx = r_idx;
    assign out_valid   = r_valid;
    assign out_data    = r_out_data;
    assign core_halt   = r_halt;
    assign done        = r_done;
    assign err         = r_err;

endmodule

// File: tb/tb_sig_dump_ctrl.sv
// Bench for sig_dump_ctrl: directed and random dumps against a range/word-list model,
// with a DRAM responder, a handshake monitor and an asynchronous mid-dump reset.
module tb_sig_dump_ctrl;

    localparam int          AW     = 14;
    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam longint      BASE_L = 64'h4000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          snoop_we = 1'b0;
    logic [31:0]   snoop_addr = '0;
    logic [31:0]   snoop_wdat = '0;
    logic          dram_rd_req;
    logic [AW-1:0] dram_rd_idx;
    logic          dram_rd_gnt = 1'b0;
    logic [31:0]   dram_rd_dat = '0;
    logic          out_valid;
    logic [31:0]   out_data;
    logic          out_ready = 1'b0;
    logic          core_halt;
    logic          done;
    logic          err;

    sig_dump_ctrl #(.DRAM_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .snoop_we(snoop_we), .snoop_addr(snoop_addr), .snoop_wdat(snoop_wdat),
        .dram_rd_req(dram_rd_req), .dram_rd_idx(dram_rd_idx),
        .dram_rd_gnt(dram_rd_gnt), .dram_rd_dat(dram_rd_dat),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .core_halt(core_halt), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int gnt_pct  = 100;
    int rdy_pct  = 100;
    int gnt_hold = 0;
    int rdy_hold = 0;
    int cyc      = 0;
    int gnt_cyc  = 0;
    int n_grant, ovl, stab, lat;
    bit pend, prev_req_stall, prev_val_stall, prev_valid;
    logic [AW-1:0] pend_idx, held_idx;
    logic [31:0]   held_dat;
    logic [31:0]   got[$];
    logic [31:0]   exp_q[$];

    function automatic logic [31:0] mem_word(input int idx);
        return (32'(idx) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Returns 0 for a clean finish, 1 for an error; fills exp_q with the words to stream.
    function automatic int model(input logic [31:0] b, input logic [31:0] e);
        longint lb = longint'(b);
        longint le = longint'(e);
        exp_q.delete();
        if (lb % 4 != 0 || le % 4 != 0) return 1;
        if (lb >= le) return 0;
        if (lb < BASE_L || (le - BASE_L) / 4 > (64'd1 << AW)) return 1;
        for (longint a = lb; a < le; a += 4)
            exp_q.push_back(mem_word(int'((a - BASE_L) / 4)));
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Grant/ready drivers and DRAM read data, changed just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (pend) begin
            dram_rd_dat = mem_word(int'(pend_idx));
            pend = 1'b0;
        end else begin
            dram_rd_dat = $urandom;
        end
        if (gnt_hold > 0) begin
            dram_rd_gnt = 1'b0;
            if (dram_rd_req) gnt_hold--;
        end else begin
            dram_rd_gnt = ($urandom_range(0, 99) < gnt_pct);
        end
        if (rdy_hold > 0) begin
            out_ready = 1'b0;
            if (out_valid) rdy_hold--;
        end else begin
            out_ready = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (dram_rd_req && out_valid) ovl++;
            if (prev_req_stall && (!dram_rd_req || dram_rd_idx !== held_idx)) stab++;
            if (prev_val_stall && (!out_valid || out_data !== held_dat)) stab++;
            if (out_valid && !prev_valid && (cyc - gnt_cyc) != 2) lat++;
            if (dram_rd_req && dram_rd_gnt) begin
                pend     = 1'b1;
                pend_idx = dram_rd_idx;
                gnt_cyc  = cyc;
                n_grant++;
            end
            if (out_valid && out_ready) got.push_back(out_data);
            prev_req_stall = dram_rd_req && !dram_rd_gnt;
            prev_val_stall = out_valid && !out_ready;
            held_idx       = dram_rd_idx;
            held_dat       = out_data;
            prev_valid     = out_valid;
        end
    end

    task automatic clear_mon();
        pend = 1'b0;
        prev_req_stall = 1'b0;
        prev_val_stall = 1'b0;
        prev_valid = 1'b0;
        n_grant = 0;
        ovl = 0;
        stab = 0;
        lat = 0;
        got.delete();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        snoop_we = 1'b0;
        gnt_hold = 0;
        rdy_hold = 0;
        clear_mon();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        snoop_we = 1'b1;
        snoop_addr = a;
        snoop_wdat = d;
        @(posedge clk);
        #1;
        snoop_we = 1'b0;
    endtask

    task automatic finish_checks(input string tag, input int kind);
        for (int k = 0; k < 3000 && !(done || err); k++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk({tag, "/finished"}, 32'(done | err), 32'd1);
        chk({tag, "/done"}, 32'(done), 32'(kind == 0));
        chk({tag, "/err"}, 32'(err), 32'(kind == 1));
        chk({tag, "/halt_sticky"}, 32'(core_halt), 32'd1);
        chk({tag, "/beats"}, 32'(got.size()), 32'(exp_q.size()));
        chk({tag, "/grants"}, 32'(n_grant), 32'(exp_q.size()));
        chk({tag, "/overlap"}, 32'(ovl), 32'd0);
        chk({tag, "/stable"}, 32'(stab), 32'd0);
        chk({tag, "/latency"}, 32'(lat), 32'd0);
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s/word%0d", tag, i), got[i], exp_q[i]);
    endtask

    task automatic run_dump(input string tag, input bit wb, input logic [31:0] b,
                            input bit we_, input logic [31:0] e,
                            input int gp, input int rp, input int gh, input int rh);
        int kind;
        apply_reset();
        gnt_pct = gp;
        rdy_pct = rp;
        if (wb) begin
            wr(32'h508, b ^ 32'h0000_0100);
            wr(32'h508, b);
        end
        if (we_) wr(32'h50c, e);
        kind = model(wb ? b : 32'd0, we_ ? e : 32'd0);
        clear_mon();
        gnt_hold = gh;
        rdy_hold = rh;
        wr(32'h600, $urandom);
        chk({tag, "/halt_next"}, 32'(core_halt), 32'd1);
        chk({tag, "/req_next"}, 32'(dram_rd_req), 32'(exp_q.size() > 0));
        chk({tag, "/done_next"}, 32'(done), 32'(kind == 0 && exp_q.size() == 0));
        chk({tag, "/err_next"}, 32'(err), 32'(kind == 1));
        wr(32'h508, $urandom);
        wr(32'h50c, $urandom);
        finish_checks(tag, kind);
    endtask

    initial begin
        int kind;
        logic [31:0] b, e;
        #2 rst_n = 1'b0;
        #1;
        chk("rst/req", 32'(dram_rd_req), 32'd0);
        chk("rst/valid", 32'(out_valid), 32'd0);
        chk("rst/data", out_data, 32'd0);
        chk("rst/flags", {29'd0, core_halt, done, err}, 32'd0);
        run_dump("basic", 1, 32'h4000_0010, 1, 32'h4000_001C, 100, 100, 0, 0);
        chk("basic/idx_first", exp_q[0], mem_word(4));
        run_dump("noprog", 0, 32'd0, 0, 32'd0, 100, 100, 0, 0);
        run_dump("misalign", 1, 32'h4000_0012, 1, 32'h4000_001C, 100, 100, 0, 0);
        run_dump("below", 1, 32'h3FFF_FFF0, 1, 32'h4000_0010, 100, 100, 0, 0);
        run_dump("ready_stall", 1, 32'h4000_0100, 1, 32'h4000_010C, 100, 100, 0, 5);
        run_dump("gnt_stall", 1, 32'h4000_0200, 1, 32'h4000_020C, 100, 100, 3, 0);
        run_dump("top_ok", 1, BASE + 32'd4 * 32'd16382, 1, BASE + 32'd4 * 32'd16384,
                 100, 100, 0, 0);
        run_dump("top_over", 1, BASE + 32'd4 * 32'd16382, 1, BASE + 32'd4 * 32'd16385,
                 100, 100, 0, 0);
        for (int s = 0; s < 12; s++) begin
            int r = int'($urandom_range(0, 9));
            int n = int'($urandom_range(0, 7));
            b = BASE + 32'd4 * $urandom_range(0, 200);
            e = b + 32'd4 * 32'(n);
            if (r == 0) b = b | 32'd2;
            if (r == 1) begin
                b = BASE - 32'd4 * $urandom_range(1, 4);
                e = BASE + 32'd4 * 32'(n);
            end
            run_dump($sformatf("rnd%0d", s), 1, b, 1, e,
                     int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        apply_reset();
        gnt_pct = 100;
        rdy_pct = 100;
        wr(32'h508, 32'h4000_0010);
        wr(32'h50c, 32'h4000_001C);
        wr(32'h600, 32'd1);
        for (int k = 0; k < 200 && got.size() < 1; k++) @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 50 && !out_valid; k++) @(negedge clk);
        chk("mid/beat2_up", 32'(out_valid), 32'd1);
        chk("mid/beat1", (got.size() > 0) ? got[0] : 32'hDEAD_BEEF, mem_word(4));
        #2 rst_n = 1'b0;
        #1;
        chk("mid/valid", 32'(out_valid), 32'd0);
        chk("mid/req", 32'(dram_rd_req), 32'd0);
        chk("mid/idx", 32'(dram_rd_idx), 32'd0);
        chk("mid/data", out_data, 32'd0);
        chk("mid/flags", {29'd0, core_halt, done, err}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_mon();
        wr(32'h508, 32'h4000_0040);
        wr(32'h50c, 32'h4000_0048);
        kind = model(32'h4000_0040, 32'h4000_0048);
        clear_mon();
        wr(32'h600, 32'd1);
        chk("mid/restart_req", 32'(dram_rd_req), 32'd1);
        chk("mid/restart_idx", 32'(dram_rd_idx), 32'd16);
        finish_checks("mid/restart", kind);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
